kamus_fetch_ctrl: RTL and testbench

Fetch controller for the kamus core front end. It owns the fetch PC and sequences the instruction-memory request/grant/response handshake toward $L1I. It presents one fetched instruction at a time to ID through a valid/ready slot. It applies ID redirects (jump/branch/flush targets) and discards in-flight responses that a redirect makes stale.

---
 rtl/kamus_pkg.sv | 20 ++
 rtl/kamus_fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_kamus_fetch_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kamus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kamus_pkg
// Description : Shared types and constants for the kamus core front end.
//               fetch_state_e - fetch controller state encoding (2-bit)
//               INSTR_BYTES   - PC increment per fetched instruction
// Revision    : 1.0 - initial release
// ============================================================================
package kamus_pkg;

    typedef enum logic [1:0] {
        F_BOOT = 2'd0,
        F_REQ  = 2'd1,
        F_WAIT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage
`default_nettype wire

// File: rtl/kamus_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kamus_fetch_ctrl
// Description : Fetch controller. Owns the fetch PC, runs the req/gnt/rvalid
//               handshake toward the L1 I-cache, holds one fetched
//               instruction in a valid/ready slot for ID, and applies ID
//               redirects while discarding responses made stale by them.
// Ports       : clk_i, rst_ni            - clock, sync active-low reset
//               imem_req_o/addr_o        - fetch request and address
//               imem_gnt_i               - address accepted this cycle
//               imem_rvalid_i/rdata_i    - response (never backpressured)
//               redirect_i/addr_i        - ID redirect strobe and target
//               id_ready_i               - ID consumes the slot
//               instr_valid_o/data_o/pc_o- slot contents
//               next_pc_o                - slot PC + 4 (link value)
// Revision    : 1.0 - initial release
// ============================================================================
module kamus_fetch_ctrl
    import kamus_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        id_ready_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_data_o,
    output logic [31:0] instr_pc_o,
    output logic [31:0] next_pc_o
);

    fetch_state_e r_state;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_req_pc;      // address of the outstanding fetch
    logic         r_kill;        // outstanding response must be dropped
    logic         r_slot_valid;
    logic [31:0]  r_slot_data;
    logic [31:0]  r_slot_pc;

    fetch_state_e w_state_nxt;
    logic [31:0]  w_fetch_pc_nxt;
    logic [31:0]  w_req_pc_nxt;
    logic         w_kill_nxt;
    logic         w_slot_valid_nxt;
    logic [31:0]  w_slot_data_nxt;
    logic [31:0]  w_slot_pc_nxt;
    logic         w_req;
    logic         w_load;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= F_BOOT;
            r_fetch_pc   <= BOOT_ADDR;
            r_req_pc     <= BOOT_ADDR;
            r_kill       <= 1'b0;
            r_slot_valid <= 1'b0;
            r_slot_data  <= 32'h0;
            r_slot_pc    <= 32'h0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_req_pc     <= w_req_pc_nxt;
            r_kill       <= w_kill_nxt;
            r_slot_valid <= w_slot_valid_nxt;
            r_slot_data  <= w_slot_data_nxt;
            r_slot_pc    <= w_slot_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_req_pc_nxt     = r_req_pc;
        w_kill_nxt       = r_kill;
        w_req            = 1'b0;
        w_load           = 1'b0;

        case (r_state)
            F_BOOT: begin
                w_state_nxt = F_REQ;
            end
            F_REQ: begin
                // Only request when the slot is guaranteed free by the time
                // the response could land, since rvalid cannot be stalled.
                w_req = !r_slot_valid || id_ready_i;
                if (w_req && imem_gnt_i) begin
                    w_state_nxt    = F_WAIT;
                    w_fetch_pc_nxt = r_fetch_pc + INSTR_BYTES;
                    w_req_pc_nxt   = r_fetch_pc;
                end
            end
            F_WAIT: begin
                if (imem_rvalid_i) begin
                    w_state_nxt = F_REQ;
                    w_kill_nxt  = 1'b0;
                    w_load      = !r_kill;
                end
            end
            default: begin
                w_state_nxt = F_BOOT;
            end
        endcase

        if (redirect_i) begin
            w_fetch_pc_nxt = redirect_addr_i;
            w_load         = 1'b0;
            // A fetch is still in flight after this edge exactly when we
            // end up (or stay) in F_WAIT; its response carries the old PC.
            w_kill_nxt     = (w_state_nxt == F_WAIT);
        end

        // Slot: cleared by a transfer, reloaded by a live response,
        // and unconditionally emptied by a redirect.
        w_slot_valid_nxt = r_slot_valid && !id_ready_i;
        w_slot_data_nxt  = r_slot_data;
        w_slot_pc_nxt    = r_slot_pc;
        if (w_load) begin
            w_slot_valid_nxt = 1'b1;
            w_slot_data_nxt  = imem_rdata_i;
            w_slot_pc_nxt    = r_req_pc;
        end
        if (redirect_i) begin
            w_slot_valid_nxt = 1'b0;
        end
    end

    assign imem_req_o    = w_req;
    assign imem_addr_o   = r_fetch_pc;
    assign instr_valid_o = r_slot_valid;
    assign instr_data_o  = r_slot_data;
    assign instr_pc_o    = r_slot_pc;
    assign next_pc_o     = r_slot_pc + INSTR_BYTES;

endmodule
`default_nettype wire

// File: tb/tb_kamus_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_kamus_fetch_ctrl
// Description : Self-checking bench for kamus_fetch_ctrl. Directed scenarios
//               push expected slot PCs into a queue; a monitor pops and
//               compares on every slot transfer to ID.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kamus_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        id_ready_i;
    logic        instr_valid_o;
    logic [31:0] instr_data_o;
    logic [31:0] instr_pc_o;
    logic [31:0] next_pc_o;

    kamus_fetch_ctrl #(.BOOT_ADDR(32'h100)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .id_ready_i      (id_ready_i),
        .instr_valid_o   (instr_valid_o),
        .instr_data_o    (instr_data_o),
        .instr_pc_o      (instr_pc_o),
        .next_pc_o       (next_pc_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] exp_q[$];
    int          xfer_cyc[$];

    // Memory responder controls
    logic        gnt_en   = 1'b0;
    int          rv_delay = 1;
    int          rv_cnt   = 0;
    logic [31:0] rv_addr  = 32'h0;
    logic        stray_rv = 1'b0;

    // Per-cycle output snapshot
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1 after the caller has set ready/redirect/reset.
    task automatic cycle();
        logic        granted;
        logic [31:0] gaddr;
        imem_gnt_i    = gnt_en;
        imem_rvalid_i = (rv_cnt == 1) || stray_rv;
        imem_rdata_i  = stray_rv ? 32'h5555_AAAA :
                        ((rv_cnt == 1) ? mem_word(rv_addr) : 32'h0);
        #1;
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_valid = instr_valid_o;
        s_pc    = instr_pc_o;
        granted = imem_req_o && imem_gnt_i;
        gaddr   = imem_addr_o;
        @(posedge clk);
        #1;
        if (rv_cnt > 0) rv_cnt--;
        if (granted) begin
            rv_cnt  = rv_delay;
            rv_addr = gaddr;
        end
    endtask

    task automatic do_reset();
        rst_ni     = 1'b0;
        gnt_en     = 1'b0;
        id_ready_i = 1'b0;
        redirect_i = 1'b0;
        stray_rv   = 1'b0;
        rv_delay   = 1;
        cycle();
        cycle();
        rv_cnt = 0;
    endtask

    task automatic drain(input int bound);
        int k = 0;
        id_ready_i = 1'b1;
        while (exp_q.size() > 0 && k < bound) begin
            cycle();
            k++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        id_ready_i = 1'b0;
    endtask

    // Scoreboard monitor: every slot transfer must match the queue head.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_ni && instr_valid_o && id_ready_i) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_slot: got pc %h, expected no transfer", instr_pc_o);
            end else begin
                e = exp_q.pop_front();
                chk("slot_pc", instr_pc_o, e);
                chk("slot_data", instr_data_o, mem_word(e));
                chk("slot_next_pc", next_pc_o, e + 32'd4);
                xfer_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        rst_ni          = 1'b0;
        imem_gnt_i      = 1'b0;
        imem_rvalid_i   = 1'b0;
        imem_rdata_i    = 32'h0;
        redirect_i      = 1'b0;
        redirect_addr_i = 32'h0;
        id_ready_i      = 1'b0;
        @(posedge clk);
        #1;

        // ---------------- reset values
        do_reset();
        chk("rst_req", {31'h0, s_req}, 32'h0);
        chk("rst_addr", s_addr, 32'h100);
        chk("rst_valid", {31'h0, s_valid}, 32'h0);
        chk("rst_data", instr_data_o, 32'h0);
        chk("rst_pc", instr_pc_o, 32'h0);
        chk("rst_next_pc", next_pc_o, 32'h4);

        // ---------------- streaming, one instruction per 2 cycles
        gnt_en = 1'b1; id_ready_i = 1'b1;
        exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
        xfer_cyc.delete();
        rst_ni = 1'b1;
        cycle();
        chk("boot_no_req", {31'h0, s_req}, 32'h0);
        cycle();
        chk("first_req", {31'h0, s_req}, 32'h1);
        chk("first_addr", s_addr, 32'h100);
        drain(20);
        if (xfer_cyc.size() == 3) begin
            chk("tput_gap0", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd2);
            chk("tput_gap1", 32'(xfer_cyc[2] - xfer_cyc[1]), 32'd2);
        end else begin
            chk("tput_count", 32'(xfer_cyc.size()), 32'd3);
        end

        // ---------------- ID stall with slot full
        do_reset();
        gnt_en = 1'b1; id_ready_i = 1'b1;
        exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
        rst_ni = 1'b1;
        repeat (5) cycle();
        id_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_req", {31'h0, s_req}, 32'h0);
            chk("stall_pc", s_pc, 32'h104);
            chk("stall_valid", {31'h0, s_valid}, 32'h1);
        end
        id_ready_i = 1'b1;
        cycle();
        chk("unstall_req", {31'h0, s_req}, 32'h1);
        drain(20);

        // ---------------- redirect while waiting, response 2 cycles later
        do_reset();
        gnt_en = 1'b1; id_ready_i = 1'b1; rv_delay = 2;
        exp_q.push_back(32'h2000);
        rst_ni = 1'b1;
        cycle();
        cycle();
        redirect_i = 1'b1; redirect_addr_i = 32'h2000;
        cycle();
        redirect_i = 1'b0;
        cycle();
        cycle();
        chk("kill_valid", {31'h0, s_valid}, 32'h0);
        chk("kill_req", {31'h0, s_req}, 32'h1);
        chk("kill_addr", s_addr, 32'h2000);
        drain(20);

        // ---------------- redirect coinciding with rvalid and ID ready
        do_reset();
        gnt_en = 1'b1; id_ready_i = 1'b1;
        exp_q.push_back(32'h100); exp_q.push_back(32'h3000);
        rst_ni = 1'b1;
        repeat (4) cycle();
        redirect_i = 1'b1; redirect_addr_i = 32'h3000;
        cycle();
        redirect_i = 1'b0;
        cycle();
        chk("rv_redir_valid", {31'h0, s_valid}, 32'h0);
        chk("rv_redir_req", {31'h0, s_req}, 32'h1);
        chk("rv_redir_addr", s_addr, 32'h3000);
        drain(20);

        // ---------------- delayed grant with redirect before it
        do_reset();
        id_ready_i = 1'b1;
        exp_q.push_back(32'h4000);
        rst_ni = 1'b1;
        cycle();
        cycle();
        chk("nognt_addr", s_addr, 32'h100);
        redirect_i = 1'b1; redirect_addr_i = 32'h4000;
        cycle();
        redirect_i = 1'b0;
        cycle();
        chk("nognt_redir_addr", s_addr, 32'h4000);
        gnt_en = 1'b1;
        drain(20);

        // ---------------- address wrap, then reset in F_WAIT with stray rvalid
        do_reset();
        id_ready_i = 1'b1;
        exp_q.push_back(32'hFFFF_FFFC);
        rst_ni = 1'b1;
        cycle();
        redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFFC;
        cycle();
        redirect_i = 1'b0; gnt_en = 1'b1;
        cycle();
        chk("wrap_req_addr", s_addr, 32'hFFFF_FFFC);
        cycle();
        cycle();
        chk("wrap_next_addr", s_addr, 32'h0);
        chk("wrap_next_req", {31'h0, s_req}, 32'h1);
        chk("wrap_pending", 32'(exp_q.size()), 32'd0);
        gnt_en = 1'b0;
        rst_ni = 1'b0;
        cycle();
        stray_rv = 1'b1;
        cycle();
        rst_ni = 1'b1;
        cycle();
        stray_rv = 1'b0;
        rv_cnt = 0;
        exp_q.push_back(32'h100);
        cycle();
        chk("stray_valid", {31'h0, s_valid}, 32'h0);
        chk("refetch_req", {31'h0, s_req}, 32'h1);
        chk("refetch_addr", s_addr, 32'h100);
        gnt_en = 1'b1;
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
